// File: rtl/reg_file_streamer_pkg.sv
// Shared definitions for the register-file sweepers (read side now, write side later).
package reg_file_streamer_pkg;

  // Sweep FSM states; the 2-bit encodings are shared with the write-side sweeper.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SEND  = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/reg_file_streamer_stream_out_reg.sv
// Output holding register for the stream: {last, data}, loaded or held each cycle.
module stream_out_reg #(
  parameter int unsigned B = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [B:0]   din,
  output logic [B:0]   dout
);

  // Capture a new {last, data} pair on load, otherwise hold it for backpressure.
  always_ff @(posedge clk) begin
    if (reset) begin
      dout <= '0;
    end else if (load) begin
      dout <= din;
    end
  end

endmodule

// File: rtl/reg_file_streamer.sv
// Read-side sweeper: walks count consecutive register-file addresses from
// start_addr (wrapping) and streams each word out on a valid/ready channel.
module reg_file_streamer
  import reg_file_streamer_pkg::*;
#(
  parameter int unsigned B = 8,
  parameter int unsigned W = 2
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [W-1:0]   start_addr,
  input  logic [W:0]     count,
  output logic [W-1:0]   r_addr,
  input  logic [B-1:0]   r_data,
  output logic [B-1:0]   m_data,
  output logic           m_valid,
  input  logic           m_ready,
  output logic           m_last,
  output logic           busy,
  output logic           done
);

  localparam int unsigned DEPTH     = 1 << W;
  localparam logic [W:0]  DEPTH_CNT = (W+1)'(DEPTH);
  localparam logic [W:0]  ONE_CNT   = (W+1)'(1);

  state_t       state;
  state_t       state_next;
  logic [W-1:0] addr_next;
  logic [W:0]   rem;
  logic [W:0]   rem_next;
  logic         valid_next;
  logic         out_load;
  logic [B:0]   out_din;
  logic [B:0]   out_q;

  stream_out_reg #(.B(B)) u_out (
    .clk   (clk),
    .reset (reset),
    .load  (out_load),
    .din   (out_din),
    .dout  (out_q)
  );

  assign m_data = out_q[B-1:0];
  assign m_last = out_q[B];
  assign busy   = (state != IDLE);
  assign done   = (state == DONE);

  // State, read address, remaining count and valid flag registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      r_addr  <= '0;
      rem     <= '0;
      m_valid <= 1'b0;
    end else begin
      state   <= state_next;
      r_addr  <= addr_next;
      rem     <= rem_next;
      m_valid <= valid_next;
    end
  end

  // Next-state logic; FETCH and an accepted non-final SEND beat share the same
  // word-capture path so throughput stays at one word per cycle.
  always_comb begin
    state_next = state;
    addr_next  = r_addr;
    rem_next   = rem;
    valid_next = m_valid;
    out_load   = 1'b0;
    out_din    = {m_last, m_data};
    case (state)
      IDLE: begin
        if (start) begin
          if (count != '0) begin
            addr_next  = start_addr;
            rem_next   = (count > DEPTH_CNT) ? DEPTH_CNT : count;
            state_next = FETCH;
          end else begin
            state_next = DONE;
          end
        end
      end
      FETCH: begin
        out_load   = 1'b1;
        out_din    = {(rem == ONE_CNT), r_data};
        valid_next = 1'b1;
        addr_next  = r_addr + 1'b1;
        rem_next   = rem - ONE_CNT;
        state_next = SEND;
      end
      SEND: begin
        if (m_valid && m_ready) begin
          if (m_last) begin
            valid_next = 1'b0;
            out_load   = 1'b1;
            out_din    = {1'b0, m_data};
            state_next = DONE;
          end else begin
            out_load   = 1'b1;
            out_din    = {(rem == ONE_CNT), r_data};
            valid_next = 1'b1;
            addr_next  = r_addr + 1'b1;
            rem_next   = rem - ONE_CNT;
          end
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_reg_file_streamer.sv
// Directed bench for reg_file_streamer with a small sync-write/async-read register file.
module tb_reg_file_streamer;

  localparam int unsigned B = 8;
  localparam int unsigned W = 2;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] start_addr = '0;
  logic [W:0]   count = '0;
  logic [W-1:0] r_addr;
  logic [B-1:0] r_data;
  logic [B-1:0] m_data;
  logic         m_valid;
  logic         m_ready = 1'b0;
  logic         m_last;
  logic         busy;
  logic         done;

  logic [B-1:0] rf [4];
  logic         we = 1'b0;
  logic [W-1:0] waddr = '0;
  logic [B-1:0] wdata = '0;

  int checks = 0;
  int errors = 0;

  int           cyc = 0;
  int           done_n = 0;
  int           done_cyc = 0;
  bit           valid_seen = 1'b0;
  logic [B-1:0] hs_data [$];
  logic         hs_last [$];
  int           hs_cyc  [$];

  reg_file_streamer #(.B(B), .W(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .start_addr (start_addr),
    .count      (count),
    .r_addr     (r_addr),
    .r_data     (r_data),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_last     (m_last),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  // Register file: async read, write lands at the clock edge.
  assign r_data = rf[r_addr];
  always @(posedge clk) if (we) rf[waddr] <= wdata;

  // Stream monitor: records every handshake and every done cycle.
  always @(posedge clk) begin
    cyc++;
    if (m_valid) valid_seen = 1'b1;
    if (m_valid && m_ready) begin
      hs_data.push_back(m_data);
      hs_last.push_back(m_last);
      hs_cyc.push_back(cyc);
    end
    if (done) begin
      done_n++;
      done_cyc = cyc;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_mon;
    hs_data.delete();
    hs_last.delete();
    hs_cyc.delete();
    done_n     = 0;
    valid_seen = 1'b0;
  endtask

  task automatic wr(input logic [W-1:0] a, input logic [B-1:0] d);
    we = 1'b1; waddr = a; wdata = d;
    tick;
    we = 1'b0;
  endtask

  task automatic start_sweep(input logic [W-1:0] a, input logic [W:0] c);
    start = 1'b1; start_addr = a; count = c;
    tick;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (done_n == 0 && n < 40) begin
      tick;
      n++;
    end
    check({tag, "_done_seen"}, 32'(done_n != 0), 32'd1);
  endtask

  task automatic check_beats(input string tag, input int n,
                             input logic [B-1:0] e0, input logic [B-1:0] e1,
                             input logic [B-1:0] e2, input logic [B-1:0] e3);
    logic [B-1:0] e [4];
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
    check({tag, "_nbeats"}, 32'(hs_data.size()), 32'(n));
    for (int i = 0; i < n && i < hs_data.size(); i++) begin
      check($sformatf("%s_data%0d", tag, i), 32'(hs_data[i]), 32'(e[i]));
      check($sformatf("%s_last%0d", tag, i), 32'(hs_last[i]), 32'(i == n - 1));
    end
  endtask

  initial begin
    // Reset state.
    tick;
    check("rst_r_addr", 32'(r_addr), 32'd0);
    check("rst_m_data", 32'(m_data), 32'd0);
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_m_last", 32'(m_last), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    reset = 1'b0;
    wr(2'd0, 8'h11);
    wr(2'd1, 8'h22);
    wr(2'd2, 8'h33);
    wr(2'd3, 8'h44);

    // Basic sweep, addr=1 count=2.
    clear_mon;
    m_ready = 1'b1;
    start_sweep(2'd1, 3'd2);
    wait_done("basic");
    check("basic_busy_after", 32'(busy), 32'd0);
    check_beats("basic", 2, 8'h22, 8'h33, 8'h00, 8'h00);
    if (hs_cyc.size() == 2) begin
      check("basic_b2b", 32'(hs_cyc[1] - hs_cyc[0]), 32'd1);
      check("basic_done_lat", 32'(done_cyc - hs_cyc[1]), 32'd1);
    end
    check("basic_r_addr", 32'(r_addr), 32'd3);
    tick; tick; tick;
    check("basic_done_once", 32'(done_n), 32'd1);

    // Wrap-around sweep, addr=3 count=4.
    clear_mon;
    start_sweep(2'd3, 3'd4);
    wait_done("wrap");
    check_beats("wrap", 4, 8'h44, 8'h11, 8'h22, 8'h33);
    check("wrap_r_addr", 32'(r_addr), 32'd3);

    // Backpressure on the first beat.
    clear_mon;
    m_ready = 1'b0;
    start_sweep(2'd0, 3'd2);
    for (int n = 0; n < 10 && !m_valid; n++) tick;
    check("bp_valid", 32'(m_valid), 32'd1);
    for (int i = 0; i < 3; i++) begin
      check("bp_hold_data", 32'(m_data), 32'h11);
      check("bp_hold_last", 32'(m_last), 32'd0);
      check("bp_hold_addr", 32'(r_addr), 32'd1);
      tick;
    end
    check("bp_still_valid", 32'(m_valid), 32'd1);
    m_ready = 1'b1;
    wait_done("bp");
    check_beats("bp", 2, 8'h11, 8'h22, 8'h00, 8'h00);

    // Empty sweep.
    clear_mon;
    start_sweep(2'd1, 3'd0);
    check("cnt0_done", 32'(done), 32'd1);
    check("cnt0_busy", 32'(busy), 32'd1);
    wait_done("cnt0");
    tick; tick; tick;
    check("cnt0_no_valid", 32'(valid_seen), 32'd0);
    check("cnt0_done_once", 32'(done_n), 32'd1);

    // Count above depth clamps to 4 beats.
    clear_mon;
    start_sweep(2'd0, 3'd7);
    wait_done("clamp");
    check_beats("clamp", 4, 8'h11, 8'h22, 8'h33, 8'h44);
    check("clamp_r_addr", 32'(r_addr), 32'd0);

    // Reset mid-sweep after the first beat.
    clear_mon;
    start_sweep(2'd0, 3'd4);
    for (int n = 0; n < 10 && hs_data.size() == 0; n++) tick;
    check("mid_first_beat", 32'(hs_data.size()), 32'd1);
    reset = 1'b1;
    tick;
    check("mid_valid", 32'(m_valid), 32'd0);
    check("mid_busy", 32'(busy), 32'd0);
    check("mid_done", 32'(done), 32'd0);
    check("mid_r_addr", 32'(r_addr), 32'd0);
    reset = 1'b0;
    tick; tick;
    check("mid_no_done", 32'(done_n), 32'd0);

    // Fresh sweep after reset, with a start pulse while busy.
    clear_mon;
    start_sweep(2'd2, 3'd2);
    start = 1'b1; start_addr = 2'd0; count = 3'd1;
    tick;
    start = 1'b0;
    wait_done("ign");
    check_beats("ign", 2, 8'h33, 8'h44, 8'h00, 8'h00);
    tick; tick; tick;
    check("ign_done_once", 32'(done_n), 32'd1);
    check("ign_idle", 32'(busy), 32'd0);
    check("ign_nbeats_after", 32'(hs_data.size()), 32'd2);

    // Write two cycles before the capture edge is seen.
    clear_mon;
    wr(2'd2, 8'hAA);
    start_sweep(2'd2, 3'd1);
    wait_done("wr_early");
    check_beats("wr_early", 1, 8'hAA, 8'h00, 8'h00, 8'h00);
    wr(2'd2, 8'h33);

    // Write on the capture edge itself is not seen.
    clear_mon;
    start_sweep(2'd2, 3'd1);
    we = 1'b1; waddr = 2'd2; wdata = 8'hBB;
    tick;
    we = 1'b0;
    wait_done("wr_same");
    check_beats("wr_same", 1, 8'h33, 8'h00, 8'h00, 8'h00);
    wr(2'd2, 8'h33);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
